// File: rtl/testeio_edge_capture_input.sv
// testeio_edge_capture_input
// Avalon-MM parallel input port. External status lines pass through a
// two-flop synchronizer (optionally a debounce filter), their level is
// readable at offset 0, and selected edges are latched in a sticky
// edge-capture register that drives a maskable level interrupt.
//
// Optional build macro: PIO_DEBOUNCE_EN
//   defined   - per-bit 8-bit counter filter after the synchronizer
//   undefined - conditioned value is the synchronizer output
//
// Bus semantics: a write is accepted on any rising clk where
// chipselect=1 and write_n=0 (no wait states, no backpressure). Reads are
// combinational from address and the registers, ignore chipselect and
// have no side effects.
module testeio_edge_capture_input #(
    parameter int WIDTH           = 1,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] interruptmask;
    logic [WIDTH-1:0] ec_clear;
    logic             wr_en;
    logic             unused_bits;

    // Upper writedata bits are don't-care; the debounce limit is only
    // consumed when the filter is built in.
    assign unused_bits = ^{writedata, DB_LAST};

    // Two-flop synchronizer for the asynchronous input lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    logic [WIDTH-1:0] filt;
    logic [7:0]       db_cnt [WIDTH];

    // Debounce: a bit follows sync2 only after it has differed for
    // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cond = filt;
`else
    assign cond = sync2;
`endif

    // Previous conditioned value for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= cond;
    end

    // Select which transition counts as an edge.
    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = cond & ~prev;
            1:       edge_hit = ~cond & prev;
            default: edge_hit = cond ^ prev;
        endcase
    end

    assign wr_en    = chipselect & ~write_n;
    assign ec_clear = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Sticky edge capture, write-1-to-clear; a simultaneous edge wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) edgecapture <= '0;
        else       edgecapture <= (edgecapture & ~ec_clear) | edge_hit;
    end

    // Interrupt mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              interruptmask <= '0;
        else if (wr_en && address == ADDR_MASK) interruptmask <= writedata[WIDTH-1:0];
    end

    // Zero-wait-state read mux, zero-extended above WIDTH-1.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = cond;
            ADDR_MASK: readdata[WIDTH-1:0] = interruptmask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edgecapture;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & interruptmask);

endmodule

// File: tb/tb_testeio_edge_capture_input.sv
// Directed bench for testeio_edge_capture_input. Three instances share the
// bus and input lines and differ only in EDGE_TYPE (rising, falling, any).
module tb_testeio_edge_capture_input;

`ifdef PIO_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_r, rd_f, rd_a;
    logic        irq_r, irq_f, irq_a;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    testeio_edge_capture_input #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));
    testeio_edge_capture_input #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));
    testeio_edge_capture_input #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one bus write at a negedge; it lands on the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic set_addr(input logic [1:0] a);
        address = a;
        #1;
    endtask

    // Read offset 3 of all three instances against expected values.
    task automatic check_ec(input string tag, input logic [3:0] er, input logic [3:0] ef, input logic [3:0] ea);
        set_addr(2'd3);
        check({tag, "_ec_rise"}, rd_r, {28'd0, er});
        check({tag, "_ec_fall"}, rd_f, {28'd0, ef});
        check({tag, "_ec_any"},  rd_a, {28'd0, ea});
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'h0;

        // Reset state at every offset.
        tick(2);
        for (int a = 0; a < 4; a++) begin
            set_addr(2'(a));
            check("reset_rd", rd_r, 32'd0);
        end
        check("reset_irq", {31'd0, irq_r}, 32'd0);
        reset = 1'b0;
        tick(3);
        check_ec("idle", 4'h0, 4'h0, 4'h0);

        // in_port 0 -> 0x5: data after 2 clocks, capture after 3.
        in_port = 4'h5;
        set_addr(2'd0);
        tick(1 + DB);
        check("data_early", rd_r, 32'd0);
        tick(1);
        check("data_5", rd_r, 32'd5);
        check_ec("pre_cap", 4'h0, 4'h0, 4'h0);
        tick(1);
        check_ec("cap5", 4'h5, 4'h0, 4'h5);
        check("irq_masked", {31'd0, irq_r}, 32'd0);

        // Writes to offsets 0/1 and writes without chipselect are ignored.
        bus_write(2'd0, 32'hF, 1'b1);
        bus_write(2'd1, 32'hF, 1'b1);
        bus_write(2'd2, 32'hF, 1'b0);
        set_addr(2'd0); check("ro_data", rd_r, 32'd5);
        set_addr(2'd1); check("rsvd", rd_r, 32'd0);
        set_addr(2'd2); check("mask_nocs", rd_r, 32'd0);

        // Unmask a captured bit: irq next cycle.
        bus_write(2'd2, 32'hFFFF_FFF4, 1'b1);
        set_addr(2'd2); check("mask_rd", rd_r, 32'd4);
        check("irq_on", {31'd0, irq_r}, 32'd1);
        check("irq_fall_off", {31'd0, irq_f}, 32'd0);
        // Clear bit 2: irq drops next cycle, bit 0 remains.
        bus_write(2'd3, 32'h4, 1'b1);
        check_ec("w1c", 4'h1, 4'h0, 4'h1);
        check("irq_cleared", {31'd0, irq_r}, 32'd0);

        // Drop bit 0 (falling edge), then re-raise it and clear in the
        // same cycle the rising edge is captured: the edge wins.
        in_port = 4'h4;
        tick(3 + DB);
        check_ec("fall0", 4'h1, 4'h1, 4'h1);
        in_port = 4'h5;
        tick(2 + DB);
        bus_write(2'd3, 32'h1, 1'b1);
        check_ec("edge_wins", 4'h1, 4'h0, 4'h1);
        bus_write(2'd3, 32'h1, 1'b1);
        check_ec("clr0", 4'h0, 4'h0, 4'h0);

        // Bit 1 toggles 0->1->0 five clocks apart, cleared after each.
        in_port = 4'h7;
        tick(5 + DB);
        check_ec("b1_up", 4'h2, 4'h0, 4'h2);
        bus_write(2'd3, 32'h2, 1'b1);
        check_ec("b1_clr", 4'h0, 4'h0, 4'h0);
        in_port = 4'h5;
        tick(5 + DB);
        check_ec("b1_down", 4'h0, 4'h2, 4'h2);

        // Masking and unmasking leave edgecapture untouched.
        bus_write(2'd2, 32'hF, 1'b1);
        check("irq_f_on", {31'd0, irq_f}, 32'd1);
        check("irq_a_on", {31'd0, irq_a}, 32'd1);
        bus_write(2'd2, 32'h0, 1'b1);
        check("irq_f_mask", {31'd0, irq_f}, 32'd0);
        check_ec("mask_keep", 4'h0, 4'h2, 4'h2);
        bus_write(2'd2, 32'hF, 1'b1);
        check("irq_f_again", {31'd0, irq_f}, 32'd1);

        // Asynchronous reset mid-cycle clears everything at once.
        #2;
        reset = 1'b1;
        #1;
        check("rst_irq_f", {31'd0, irq_f}, 32'd0);
        check("rst_irq_a", {31'd0, irq_a}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            set_addr(2'(a));
            check("rst_rd_f", rd_f, 32'd0);
            check("rst_rd_a", rd_a, 32'd0);
        end
        tick(2);
        reset = 1'b0;

        // Release with in_port held high: rising/any capture the 0->1.
        tick(3 + DB);
        check_ec("rel_high", 4'h5, 4'h0, 4'h5);
        bus_write(2'd3, 32'hF, 1'b1);
        check_ec("rel_clr", 4'h0, 4'h0, 4'h0);

`ifdef PIO_DEBOUNCE_EN
        // Three-clock glitch on bit 3 is filtered out.
        in_port = 4'hD;
        tick(3);
        in_port = 4'h5;
        tick(10);
        check_ec("glitch", 4'h0, 4'h0, 4'h0);
        // Sustained high on bit 3 captures DEBOUNCE_CYCLES clocks late.
        in_port = 4'hD;
        tick(2 + DB);
        check_ec("db_wait", 4'h0, 4'h0, 4'h0);
        tick(1);
        check_ec("db_cap", 4'h8, 4'h0, 4'h8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
